// File: rtl/ppf_pkg.sv
// Shared definitions for the polyphase filter front end: frame sequencer state
// encoding and default phase geometry.
package ppf_pkg;

   localparam int PPF_N_PHASE = 8;
   localparam int PPF_PHASE_W = $clog2(PPF_N_PHASE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_PAD  = 2'd3
   } ppf_state_t;

endpackage

// File: rtl/ppf_frame_ctrl.sv
// Frame sequencer between the AXI-Stream input and the N-phase commutator:
// tags samples with a phase index, zero-pads short frames and counts frames.
module ppf_frame_ctrl
   import ppf_pkg::*;
#(
   parameter int TDATA_WIDTH = 32,
   parameter int N_PHASE     = PPF_N_PHASE,
   parameter int CNT_WIDTH   = 16,
   localparam int PHASE_W    = $clog2(N_PHASE)
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic                   enable_i,
   input  logic                   pp_ready_i,
   input  logic                   clr_err_i,
   input  logic [TDATA_WIDTH-1:0] TDATA,
   input  logic                   TVALID,
   input  logic                   TLAST,
   output logic                   TREADY,
   output logic                   smp_valid_o,
   output logic [TDATA_WIDTH-1:0] smp_data_o,
   output logic [PHASE_W-1:0]     smp_phase_o,
   output logic                   smp_pad_o,
   output logic                   frame_done_o,
   output logic [CNT_WIDTH-1:0]   frame_cnt_o,
   output logic                   short_frame_o
);

   ppf_state_t             r_state;
   ppf_state_t             w_state_nxt;
   logic [PHASE_W-1:0]     r_phase;
   logic                   r_smp_valid;
   logic [TDATA_WIDTH-1:0] r_smp_data;
   logic [PHASE_W-1:0]     r_smp_phase;
   logic                   r_smp_pad;
   logic                   r_frame_done;
   logic [CNT_WIDTH-1:0]   r_frame_cnt;
   logic                   r_short;

   logic w_hs;
   logic w_pad_cyc;
   logic w_adv;
   logic w_last_ph;
   logic w_frame_end;
   logic w_short_set;

   // TREADY decodes registered state only, so it never depends on TVALID.
   assign TREADY      = (r_state == ST_RUN);
   assign w_hs        = TVALID & TREADY;
   assign w_pad_cyc   = (r_state == ST_PAD);
   assign w_adv       = w_hs | w_pad_cyc;
   assign w_last_ph   = (r_phase == PHASE_W'(N_PHASE - 1));
   assign w_frame_end = w_adv & w_last_ph;
   assign w_short_set = w_hs & TLAST & ~w_last_ph;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable_i) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (!enable_i)       w_state_nxt = ST_IDLE;
            else if (pp_ready_i) w_state_nxt = ST_RUN;
         end
         ST_RUN, ST_PAD: begin
            // A started frame always completes; enable_i is only sampled at its end.
            if (w_frame_end) begin
               if (enable_i && pp_ready_i) w_state_nxt = ST_RUN;
               else if (enable_i)          w_state_nxt = ST_WAIT;
               else                        w_state_nxt = ST_IDLE;
            end else if (w_short_set) begin
               w_state_nxt = ST_PAD;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_phase      <= '0;
         r_smp_valid  <= 1'b0;
         r_smp_data   <= '0;
         r_smp_phase  <= '0;
         r_smp_pad    <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_short      <= 1'b0;
      end else begin
         r_smp_valid  <= w_adv;
         r_smp_pad    <= w_pad_cyc;
         r_frame_done <= w_frame_end;
         if (w_adv) begin
            r_smp_data  <= w_hs ? TDATA : '0;
            r_smp_phase <= r_phase;
            r_phase     <= r_phase + PHASE_W'(1);
         end
         if (w_frame_end) r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
         // A new short frame wins over a simultaneous clear.
         if (w_short_set)    r_short <= 1'b1;
         else if (clr_err_i) r_short <= 1'b0;
      end
   end

   assign smp_valid_o   = r_smp_valid;
   assign smp_data_o    = r_smp_data;
   assign smp_phase_o   = r_smp_phase;
   assign smp_pad_o     = r_smp_pad;
   assign frame_done_o  = r_frame_done;
   assign frame_cnt_o   = r_frame_cnt;
   assign short_frame_o = r_short;

endmodule
